xor_stream_cipher_nch: RTL and testbench

Parametrised N-channel, W-bit-wide XOR stream cipher, successor to the dual single-bit XOR cipher. Each channel encrypts or decrypts one W-bit beat per cycle under valid/ready flow control. Every channel draws keystream from a shared M-bit key, using one of two modes:
- plain key rotation;
- Galois LFSR advance.

The key and the LFSR tap mask are loaded through a serial config chain that can be daisy-chained across cipher instances. The block sits between the TinyTapeout pin wrapper and user data sources and sinks.

---
 rtl/xor_cipher_pkg.sv | 42 ++++
 rtl/xor_cipher_channel.sv | 66 ++++++
 rtl/xor_stream_cipher_nch.sv | 102 ++++++++++
 tb/tb_xor_stream_cipher_nch.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_cipher_pkg.sv
// Shared constants and the keystream advance function for the N-channel XOR stream cipher.
package xor_cipher_pkg;

    localparam logic MODE_ROT  = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    // Widest keystream the advance function handles; callers pass their own M (<= KS_MAX).
    localparam int KS_MAX = 256;

    typedef logic [KS_MAX-1:0] ks_wide_t;

    // Advance a keystream by one beat of w bits within an m-bit register.
    // w and m are elaboration-time constants at every call site, so the shifts and the
    // step loop fold to fixed wiring / an unrolled XOR network.
    function automatic ks_wide_t ks_advance(
        input ks_wide_t ks,
        input ks_wide_t taps,
        input logic     mode,
        input int       w,
        input int       m
    );
        ks_wide_t mask;
        ks_wide_t res;
        logic     lsb;
        mask = {KS_MAX{1'b1}} >> (KS_MAX - m);
        if (mode == MODE_ROT) begin
            res = ((ks >> w) | (ks << (m - w))) & mask;
        end else begin
            // Galois steps; an all-zero register stays zero (no lockup guard by design).
            res = ks & mask;
            for (int s = 0; s < w; s++) begin
                lsb = res[0];
                res = res >> 1;
                if (lsb) begin
                    res = res ^ (taps & mask);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/xor_cipher_channel.sv
// One cipher channel: keystream register, single-entry output register and valid/ready handshake.
module xor_cipher_channel
    import xor_cipher_pkg::*;
#(
    parameter int W = 8,
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cfg_en,
    input  logic         sync,
    input  logic         mode,
    input  logic [M-1:0] key,
    input  logic [M-1:0] taps,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         accept
);

    logic [M-1:0] ks_q;
    logic [M-1:0] ks_d;
    logic [M-1:0] eff;
    logic         m_valid_q;
    logic         m_valid_d;
    logic [W-1:0] m_data_q;
    logic [W-1:0] m_data_d;

    // Handshake and next-state: a sync reloads the keystream in the same cycle it is used,
    // so a beat accepted alongside sync is encrypted with the key itself.
    always_comb begin
        eff       = sync ? key : ks_q;
        s_ready   = ~cfg_en & (~m_valid_q | m_ready);
        accept    = s_valid & s_ready;
        ks_d      = eff;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (accept) begin
            ks_d      = M'(ks_advance(ks_wide_t'(eff), ks_wide_t'(taps), mode, W, M));
            m_valid_d = 1'b1;
            m_data_d  = s_data ^ eff[W-1:0];
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // Channel state registers; reset drops any beat in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ks_q      <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            ks_q      <= ks_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

endmodule

// File: rtl/xor_stream_cipher_nch.sv
// N-channel W-bit XOR stream cipher: serial {taps, key} config chain, implicit sync on
// config exit, per-channel cipher slices and an accepted-beat heartbeat counter.
module xor_stream_cipher_nch
    import xor_cipher_pkg::*;
#(
    parameter int W  = 8,
    parameter int M  = 32,
    parameter int N  = 2,
    parameter int HB = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_en,
    input  logic           cfg_i,
    output logic           cfg_o,
    input  logic           mode,
    input  logic           sync,
    input  logic [N-1:0]   s_valid,
    output logic [N-1:0]   s_ready,
    input  logic [N*W-1:0] s_data,
    output logic [N-1:0]   m_valid,
    input  logic [N-1:0]   m_ready,
    output logic [N*W-1:0] m_data,
    output logic [HB-1:0]  heartbeat
);

    logic [M-1:0]  key_q;
    logic [M-1:0]  key_d;
    logic [M-1:0]  taps_q;
    logic [M-1:0]  taps_d;
    logic          cfg_en_q;
    logic          cfg_en_d;
    logic          sync_int;
    logic [N-1:0]  accept;
    logic [HB-1:0] hb_q;
    logic [HB-1:0] hb_d;

    // Config chain shifts as one 2M-bit register: cfg_i enters key LSB, key MSB feeds taps LSB.
    always_comb begin
        key_d    = key_q;
        taps_d   = taps_q;
        cfg_en_d = cfg_en;
        if (cfg_en) begin
            taps_d = {taps_q[M-2:0], key_q[M-1]};
            key_d  = {key_q[M-2:0], cfg_i};
        end
    end

    // Leaving config mode reloads every keystream from the freshly loaded key.
    assign sync_int = sync | (cfg_en_q & ~cfg_en);

    for (genvar i = 0; i < N; i++) begin : g_ch
        xor_cipher_channel #(
            .W (W),
            .M (M)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .cfg_en  (cfg_en),
            .sync    (sync_int),
            .mode    (mode),
            .key     (key_q),
            .taps    (taps_q),
            .s_valid (s_valid[i]),
            .s_ready (s_ready[i]),
            .s_data  (s_data[i*W +: W]),
            .m_valid (m_valid[i]),
            .m_ready (m_ready[i]),
            .m_data  (m_data[i*W +: W]),
            .accept  (accept[i])
        );
    end

    // Heartbeat advances by the number of beats accepted this cycle, wrapping at 2^HB.
    always_comb begin
        hb_d = hb_q;
        for (int i = 0; i < N; i++) begin
            if (accept[i]) begin
                hb_d = hb_d + HB'(1);
            end
        end
    end

    // Top-level registers: config chain, cfg_en history and heartbeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q    <= '0;
            taps_q   <= '0;
            cfg_en_q <= 1'b0;
            hb_q     <= '0;
        end else begin
            key_q    <= key_d;
            taps_q   <= taps_d;
            cfg_en_q <= cfg_en_d;
            hb_q     <= hb_d;
        end
    end

    assign cfg_o     = taps_q[M-1];
    assign heartbeat = hb_q;

endmodule

// File: tb/tb_xor_stream_cipher_nch.sv
// Self-checking bench for xor_stream_cipher_nch: directed vector tables plus a randomized run,
// all checked against a cycle-level reference model of the cipher rules.
module tb_xor_stream_cipher_nch;

    localparam int W  = 8;
    localparam int M  = 32;
    localparam int N  = 2;
    localparam int HB = 3;

    logic           clk     = 1'b0;
    logic           rst_n   = 1'b0;
    logic           cfg_en  = 1'b0;
    logic           cfg_i   = 1'b0;
    logic           mode    = 1'b0;
    logic           sync    = 1'b0;
    logic [N-1:0]   s_valid = '0;
    logic [N-1:0]   m_ready = '0;
    logic [N*W-1:0] s_data  = '0;
    logic           cfg_o;
    logic [N-1:0]   s_ready;
    logic [N-1:0]   m_valid;
    logic [N*W-1:0] m_data;
    logic [HB-1:0]  heartbeat;

    xor_stream_cipher_nch #(.W(W), .M(M), .N(N), .HB(HB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_en    (cfg_en),
        .cfg_i     (cfg_i),
        .cfg_o     (cfg_o),
        .mode      (mode),
        .sync      (sync),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .heartbeat (heartbeat)
    );

    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // Reference model state
    logic [M-1:0]  r_key;
    logic [M-1:0]  r_taps;
    logic [M-1:0]  r_ks [N];
    logic [N-1:0]  r_mv;
    logic [W-1:0]  r_md [N];
    logic [HB-1:0] r_hb;
    logic          r_cfg_prev;

    typedef struct packed {
        logic [W-1:0] din;
        logic [W-1:0] dout;
    } vec_t;

    vec_t rot_tab  [5];
    vec_t lfsr_tab [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Keystream advance straight from the rules: rotate right by W, or W Galois steps.
    function automatic logic [M-1:0] ref_adv(input logic [M-1:0] ks, input logic [M-1:0] taps,
                                             input logic md);
        logic [2*M-1:0] dbl;
        logic [M-1:0]   v;
        if (!md) begin
            dbl = {ks, ks} >> W;
            return dbl[M-1:0];
        end
        v = ks;
        for (int s = 0; s < W; s++) begin
            if (v[0]) v = (v >> 1) ^ taps;
            else      v = v >> 1;
        end
        return v;
    endfunction

    task automatic model_reset();
        r_key      = '0;
        r_taps     = '0;
        r_mv       = '0;
        r_hb       = '0;
        r_cfg_prev = 1'b0;
        for (int i = 0; i < N; i++) begin
            r_ks[i] = '0;
            r_md[i] = '0;
        end
    endtask

    // One clock: check s_ready for the current inputs, predict, clock, compare all outputs.
    task automatic cycle();
        logic [N-1:0]   exp_rdy;
        logic [M-1:0]   nks [N];
        logic [N-1:0]   nmv;
        logic [W-1:0]   nmd [N];
        logic [HB-1:0]  nhb;
        logic [2*M-1:0] chain;
        logic [M-1:0]   eff;
        logic           sy;
        logic [N*W-1:0] exp_md;
        #1;
        sy  = sync | (r_cfg_prev & ~cfg_en);
        nhb = r_hb;
        for (int i = 0; i < N; i++) begin
            exp_rdy[i] = ~cfg_en & (~r_mv[i] | m_ready[i]);
            eff        = sy ? r_key : r_ks[i];
            nks[i]     = eff;
            nmv[i]     = r_mv[i];
            nmd[i]     = r_md[i];
            if (s_valid[i] && exp_rdy[i]) begin
                nmd[i] = s_data[i*W +: W] ^ eff[W-1:0];
                nks[i] = ref_adv(eff, r_taps, mode);
                nmv[i] = 1'b1;
                nhb    = nhb + HB'(1);
            end else if (m_ready[i]) begin
                nmv[i] = 1'b0;
            end
        end
        check("s_ready", s_ready, exp_rdy);
        chain = {r_taps, r_key};
        if (cfg_en) chain = {chain[2*M-2:0], cfg_i};
        r_cfg_prev = cfg_en;
        @(posedge clk);
        #1;
        {r_taps, r_key} = chain;
        r_ks = nks;
        r_mv = nmv;
        r_md = nmd;
        r_hb = nhb;
        for (int i = 0; i < N; i++) exp_md[i*W +: W] = r_md[i];
        check("m_valid", m_valid, r_mv);
        check("m_data", m_data, exp_md);
        check("heartbeat", heartbeat, r_hb);
        check("cfg_o", cfg_o, r_taps[M-1]);
    endtask

    // Shift {taps, key} in MSB first; optionally check cfg_o replays the previous taps.
    task automatic load_cfg(input logic [M-1:0] taps, input logic [M-1:0] key,
                            input logic chk_old, input logic [M-1:0] old_taps);
        logic [2*M-1:0] bits;
        bits = {taps, key};
        for (int k = 0; k < 2*M; k++) begin
            cfg_en = 1'b1;
            cfg_i  = bits[2*M-1-k];
            if (chk_old && k < M) check("cfg_o_old_taps", cfg_o, old_taps[M-1-k]);
            #1;
            check("s_ready_cfg", s_ready, '0);
            cycle();
        end
        cfg_en = 1'b0;
        cfg_i  = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, want finish before 1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [HB-1:0] hb0;
        logic [W-1:0]  pt [4];
        logic [W-1:0]  rx [4];
        int            got;

        rot_tab[0]  = '{din: 8'h00, dout: 8'h44};
        rot_tab[1]  = '{din: 8'h00, dout: 8'h33};
        rot_tab[2]  = '{din: 8'h00, dout: 8'h22};
        rot_tab[3]  = '{din: 8'h00, dout: 8'h11};
        rot_tab[4]  = '{din: 8'h00, dout: 8'h44};
        lfsr_tab[0] = '{din: 8'h3C, dout: 8'hC3};
        lfsr_tab[1] = '{din: 8'h3C, dout: 8'h3C};
        pt[0] = 8'hDE; pt[1] = 8'hAD; pt[2] = 8'hBE; pt[3] = 8'hEF;

        // Reset state
        #12;
        check("rst_m_valid", m_valid, '0);
        check("rst_m_data", m_data, '0);
        check("rst_cfg_o", cfg_o, 1'b0);
        check("rst_heartbeat", heartbeat, '0);
        check("rst_s_ready", s_ready, 2'b11);
        #1 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // Rotate mode
        load_cfg(32'h0, 32'h11223344, 1'b0, '0);
        mode    = 1'b0;
        m_ready = '1;
        for (int k = 0; k < 5; k++) begin
            s_valid = 2'b01;
            s_data  = {8'h00, rot_tab[k].din};
            cycle();
            check("rot_data", m_data[W-1:0], rot_tab[k].dout);
            check("rot_valid", m_valid[0], 1'b1);
        end
        s_valid = '0;
        cycle();
        check("rot_heartbeat", heartbeat, 3'd5);

        // LFSR mode with zero taps: keystream collapses to zero after one advance
        load_cfg(32'h0, 32'h000000FF, 1'b0, '0);
        mode = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s_valid = 2'b01;
            s_data  = {8'h00, lfsr_tab[k].din};
            cycle();
            check("lfsr_data", m_data[W-1:0], lfsr_tab[k].dout);
        end
        s_valid = '0;
        cycle();

        // Backpressure on channel 0
        hb0     = heartbeat;
        m_ready = 2'b10;
        s_valid = 2'b01;
        s_data  = {8'h00, 8'hA5};
        cycle();
        check("bp_first", m_data[W-1:0], 8'hA5);
        s_data = {8'h00, 8'h5A};
        #1;
        check("bp_not_ready", s_ready[0], 1'b0);
        cycle();
        check("bp_held", m_data[W-1:0], 8'hA5);
        check("bp_heartbeat", heartbeat, HB'(hb0 + HB'(1)));
        cycle();
        check("bp_held2", m_data[W-1:0], 8'hA5);
        m_ready = 2'b11;
        cycle();
        check("bp_second", m_data[W-1:0], 8'h5A);
        s_valid = '0;
        cycle();
        check("bp_drained", m_valid[0], 1'b0);
        check("bp_heartbeat2", heartbeat, HB'(hb0 + HB'(2)));

        // Round trip: channel 0 encrypts, channel 1 decrypts with the same beat index
        load_cfg(32'h80200003, 32'hCAFEBABE, 1'b0, '0);
        mode    = 1'b1;
        m_ready = 2'b11;
        got     = 0;
        for (int k = 0; k < 8; k++) begin
            s_valid[0]        = (k < 4);
            s_data[W-1:0]     = (k < 4) ? pt[k] : 8'h00;
            s_valid[1]        = m_valid[0];
            s_data[W +: W]    = m_data[W-1:0];
            cycle();
            if (m_valid[1] && got < 4) begin
                rx[got] = m_data[W +: W];
                got++;
            end
        end
        s_valid = '0;
        check("rt_count", got, 4);
        for (int k = 0; k < 4; k++) check("rt_plain", (k < got) ? rx[k] : 8'hxx, pt[k]);

        // Config mid-stream with a held output beat
        m_ready = 2'b00;
        s_valid = 2'b01;
        s_data  = {8'h00, 8'h77};
        cycle();
        load_cfg(32'h12345678, 32'h0BADF00D, 1'b1, 32'h80200003);
        check("mid_held_valid", m_valid[0], 1'b1);
        m_ready = 2'b01;
        s_data  = {8'h00, 8'h00};
        cycle();
        check("mid_new_key", m_data[W-1:0], 8'h0D);
        m_ready = 2'b00;
        s_valid = '0;
        cycle();
        check("mid_valid_before_rst", m_valid[0], 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_m_valid", m_valid, '0);
        check("async_rst_m_data", m_data, '0);
        check("async_rst_heartbeat", heartbeat, '0);
        check("async_rst_cfg_o", cfg_o, 1'b0);
        model_reset();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Randomized run against the model
        load_cfg($urandom | 32'h80000001, $urandom, 1'b0, '0);
        for (int c = 0; c < 2000; c++) begin
            cfg_en  = ($urandom_range(0, 24) == 0);
            cfg_i   = 1'($urandom_range(0, 1));
            sync    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 31) == 0) mode = ~mode;
            s_valid = N'($urandom);
            m_ready = N'($urandom) | N'($urandom);
            s_data  = (N*W)'($urandom);
            cycle();
        end
        cfg_en  = 1'b0;
        sync    = 1'b0;
        s_valid = '0;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
